nts_rx_access_port: RTL
=======================

# nts_rx_access_port

Receive packet buffer with a byte-addressed random-access read port. It sits directly upstream of the NTS parser controller. It stores the 64-bit packet words streamed in during initial processing. It then serves the parser's 8/16/32/64-bit reads at any byte address, including reads that straddle a 64-bit word boundary, using a wait/data-valid handshake.

## Interface
- ADDR_WIDTH, 10, word address width; buffer holds 2^ADDR_WIDTH 64-bit words.
- i_clk  in  1  clock.
- i_areset  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous clear: word count, FSM, outputs to reset values.
- i_write_en  in  1  store i_write_data at next sequential word address.
- i_write_data  in  64  packet word; byte 0 (lowest address) in [63:56].
- o_word_count  out  ADDR_WIDTH+1  number of words stored since clear.
- o_overflow  out  1  sticky; a write was dropped because the buffer was full.
- i_rd_en  in  1  read request; sampled only when the block is not busy.
- i_rd_addr  in  ADDR_WIDTH+3  byte address.
- i_rd_wordsize  in  3  0:8, 1:16, 2:32, 3:64 bit; 4-7 illegal.
- o_wait  out  1  read port busy.
- o_rd_dv  out  1  one-cycle strobe; o_rd_data/o_rd_error valid.
- o_rd_data  out  64  result, right-aligned, upper bytes zero.
- o_rd_error  out  1  request illegal or out of bounds; o_rd_data is 0.

## Operation
- Reset values (areset and clear): all outputs 0; word count 0; FSM IDLE. RAM contents are not cleared.
- Write side: simple dual-port RAM, independent of reads.
  - On i_write_en with word count < 2^ADDR_WIDTH: write at address word count, then count+1.
  - When full, the write is dropped and o_overflow is set to 1.
- Read decode at acceptance: w = addr[ADDR_WIDTH+2:3], off = addr[2:0], n = 1<<wordsize bytes; crossing when off+n > 8.
  - Crossing is possible for 16-bit at off 7, 32-bit at off 5..7, 64-bit at off 1..7.
- Error cases, each producing o_rd_dv with o_rd_error=1 and data 0 at single-word latency; no RAM access:
  - wordsize > 3;
  - w >= o_word_count;
  - crossing with w+1 >= o_word_count.
  - Word count is sampled at acceptance.
- FSM:
  - IDLE: on i_rd_en, latch the request. Go to ERR if the request is illegal, else to RD0.
  - RD0: RAM read of w. Go to RD1 if crossing, else to OUT.
  - RD1: capture word w; RAM read of w+1. Go to OUT.
  - OUT: form the 128-bit value {word w, word w+1 or 0}. Extract bytes off..off+n-1, byte off most significant. Register into o_rd_data, pulse o_rd_dv, go to IDLE.
  - ERR: pulse o_rd_dv with o_rd_error=1, go to IDLE.
- o_wait = (state != IDLE) OR i_rd_en. This is combinational so a requester that registers its rd_en sees wait in the request cycle. o_wait is 0 in the cycle o_rd_dv is high.
- i_rd_en while not IDLE is ignored; no queueing.
- o_rd_data holds its value until the next o_rd_dv, i_clear or reset.
- A read issued in the same cycle as the write of its word is out of bounds, because the count has not yet incremented.
- i_clear or reset mid-read aborts the read; no o_rd_dv follows.

## Timing
- Request sampled at edge E0.
- Non-crossing read or error: o_rd_dv high in the cycle after edge E0+2.
- Crossing read: o_rd_dv high in the cycle after edge E0+3.
- Back-to-back throughput: next request can be sampled at the edge that ends the o_rd_dv cycle.
- Writes: o_word_count updates at the edge that samples i_write_en; one write per cycle.
- RAM read latency is 1 cycle, registered output.

## Test plan
- Write words 0x0011223344556677, 0x8899AABBCCDDEEFF; 32-bit read at byte 2 -> o_rd_data=0x22334455, o_rd_error=0, dv 2 cycles after acceptance; o_wait high in the request cycle.
- Same data; 32-bit read at byte 6 -> 0x66778899, dv 3 cycles after acceptance; 64-bit read at byte 1 -> 0x1122334455667788; 8-bit read at byte 15 -> 0xFF.
- 2 words stored; 16-bit read at byte 16 -> error, data 0. 16-bit read at byte 15 (crossing into word 2) -> error. 64-bit read at byte 8 -> 0x8899AABBCCDDEEFF.
- Wordsize 5 -> o_rd_error=1 at 2-cycle latency. Extra i_rd_en pulses while busy produce no extra dv.
- ADDR_WIDTH=2: five writes -> o_word_count=4, o_overflow=1; word 3 readable, word 4 read -> error.
- Accept a crossing read, assert i_clear in RD1 -> no o_rd_dv; count 0; any read afterwards -> error.

Source files
------------

// File: rtl/nts_rx_access_port.sv
// NTS receive packet buffer: sequential 64-bit word writes, byte-addressed
// 8/16/32/64-bit reads (word-straddling allowed) with a wait/dv handshake.
module nts_rx_access_port #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_clear,
    input  logic                  i_write_en,
    input  logic [63:0]           i_write_data,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_overflow,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH+2:0] i_rd_addr,
    input  logic [2:0]            i_rd_wordsize,
    output logic                  o_wait,
    output logic                  o_rd_dv,
    output logic [63:0]           o_rd_data,
    output logic                  o_rd_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] W_ONE   = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_OUT,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [ADDR_WIDTH-1:0] w_q, w_d;
    logic [2:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  cross_q, cross_d;
    logic                  err_q, err_d;
    logic [63:0]           hi_q, hi_d;
    logic                  dv_q, dv_d;
    logic [63:0]           data_q, data_d;
    logic                  rderr_q, rderr_d;

    logic [63:0]           mem [DEPTH];
    logic [63:0]           ram_rdata_q;
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;

    logic [ADDR_WIDTH-1:0] req_w;
    logic [2:0]            req_off;
    logic [3:0]            req_n;
    logic                  req_cross;
    logic                  req_bad;

    logic [63:0]           word_hi;
    logic [63:0]           word_lo;
    logic [127:0]          pair;
    logic [5:0]            shr;
    logic [63:0]           extract;

    // Write side: append at the current count while space remains.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        ram_we  = 1'b0;
        if (i_clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (i_write_en) begin
            if (!count_q[ADDR_WIDTH]) begin
                ram_we  = 1'b1;
                count_d = count_q + CNT_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            mem[count_q[ADDR_WIDTH-1:0]] <= i_write_data;
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_raddr];
        end
    end

    // Request decode against the word count at acceptance.
    always_comb begin
        req_w     = i_rd_addr[ADDR_WIDTH+2:3];
        req_off   = i_rd_addr[2:0];
        req_n     = 4'd1 << i_rd_wordsize[1:0];
        req_cross = ({1'b0, req_off} + req_n) > 4'd8;
        req_bad   = i_rd_wordsize[2]
                  | ({1'b0, req_w} >= count_q)
                  | (req_cross && (({1'b0, req_w} + CNT_ONE) >= count_q));
    end

    // Byte off of {word w, word w+1 or 0} lands at the top, then right-align.
    always_comb begin
        word_hi = cross_q ? hi_q : ram_rdata_q;
        word_lo = cross_q ? ram_rdata_q : 64'd0;
        pair    = {word_hi, word_lo} << {off_q, 3'b000};
        shr     = 6'd0;
        unique case (size_q)
            2'd0: shr = 6'd56;
            2'd1: shr = 6'd48;
            2'd2: shr = 6'd32;
            2'd3: shr = 6'd0;
            default: shr = 6'd0;
        endcase
        extract = pair[127:64] >> shr;
    end

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        off_d     = off_q;
        size_d    = size_q;
        cross_d   = cross_q;
        err_d     = err_q;
        hi_d      = hi_q;
        dv_d      = 1'b0;
        data_d    = data_q;
        rderr_d   = rderr_q;
        ram_re    = 1'b0;
        ram_raddr = w_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_rd_en) begin
                    w_d     = req_w;
                    off_d   = req_off;
                    size_d  = i_rd_wordsize[1:0];
                    cross_d = req_cross;
                    err_d   = req_bad;
                    state_d = req_bad ? S_ERR : S_RD0;
                end
            end
            S_RD0: begin
                ram_re  = 1'b1;
                state_d = cross_q ? S_RD1 : S_OUT;
            end
            S_RD1: begin
                ram_re    = 1'b1;
                ram_raddr = w_q + W_ONE;
                hi_d      = ram_rdata_q;
                state_d   = S_OUT;
            end
            // Errors take the same two-cycle path as a single-word read.
            S_ERR: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                dv_d    = 1'b1;
                rderr_d = err_q;
                data_d  = err_q ? 64'd0 : extract;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_clear) begin
            state_d = S_IDLE;
            dv_d    = 1'b0;
            data_d  = 64'd0;
            rderr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
            w_q     <= '0;
            off_q   <= '0;
            size_q  <= '0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            dv_q    <= 1'b0;
            data_q  <= '0;
            rderr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            w_q     <= w_d;
            off_q   <= off_d;
            size_q  <= size_d;
            cross_q <= cross_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            rderr_q <= rderr_d;
        end
    end

    assign o_word_count = count_q;
    assign o_overflow   = ovf_q;
    assign o_wait       = (state_q != S_IDLE) | i_rd_en;
    assign o_rd_dv      = dv_q;
    assign o_rd_data    = data_q;
    assign o_rd_error   = rderr_q;

endmodule
